// File: rtl/motor_ramp_ctrl.sv
// Soft-start motor ramp controller: walks a PWM duty toward a target in
// fixed steps with selectable dwell, ramp-down on stop and estop override.
module motor_ramp_ctrl #(
    parameter int DUTY_W     = 8,
    parameter int STEP       = 8,
    parameter int DWELL_W    = 16,
    parameter int DWELL_SLOW = 1000,
    parameter int DWELL_FAST = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              run,
    input  logic              fast,
    input  logic              estop,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm,
    output logic              busy,
    output logic              at_speed,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [DUTY_W:0]    STEP_X    = (DUTY_W+1)'(STEP);
    localparam logic [DWELL_W-1:0] LAST_SLOW = DWELL_W'(DWELL_SLOW - 1);
    localparam logic [DWELL_W-1:0] LAST_FAST = DWELL_W'(DWELL_FAST - 1);

    state_t              state_q;
    state_t              state_d;
    logic [DWELL_W-1:0]  dwell_q;
    logic [DWELL_W-1:0]  dwell_d;
    logic [DWELL_W-1:0]  dwell_last;
    logic [DUTY_W-1:0]   duty_q;
    logic [DUTY_W-1:0]   duty_d;
    logic [DUTY_W-1:0]   tgt;
    logic [DUTY_W-1:0]   stepped;
    logic [DUTY_W-1:0]   pwm_cnt;
    logic [DUTY_W:0]     up_x;
    logic [DUTY_W:0]     dn_x;
    logic                pwm_q;
    logic                tick;

    assign tgt        = run ? target : '0;
    assign dwell_last = fast ? LAST_FAST : LAST_SLOW;
    assign tick       = dwell_q >= dwell_last;
    assign up_x       = {1'b0, duty_q} + STEP_X;
    assign dn_x       = {1'b0, duty_q} - STEP_X;

    // One extra bit keeps both directions saturating instead of wrapping
    always_comb begin
        stepped = duty_q;
        if (duty_q < tgt) begin
            if (up_x > {1'b0, tgt})
                stepped = tgt;
            else
                stepped = up_x[DUTY_W-1:0];
        end else if (duty_q > tgt) begin
            if (dn_x[DUTY_W] || (dn_x < {1'b0, tgt}))
                stepped = tgt;
            else
                stepped = dn_x[DUTY_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        duty_d  = duty_q;
        unique case (state_q)
            RAMP: begin
                if ((duty_q == tgt) && (tgt != '0)) begin
                    state_d = HOLD;
                end else if ((duty_q == '0) && (tgt == '0)) begin
                    state_d = IDLE;
                end else if (tick) begin
                    dwell_d = '0;
                    duty_d  = stepped;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            HOLD: begin
                if (duty_q != tgt) begin
                    state_d = RAMP;
                    dwell_d = '0;
                end
            end
            default: begin
                duty_d = '0;
                if (tgt != '0) begin
                    state_d = RAMP;
                    dwell_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dwell_q <= '0;
            duty_q  <= '0;
            pwm_cnt <= '0;
            pwm_q   <= 1'b0;
        end else if (estop) begin
            state_q <= IDLE;
            dwell_q <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            if (ena)
                pwm_cnt <= pwm_cnt + 1'b1;
        end else if (ena) begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            duty_q  <= duty_d;
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_q   <= pwm_cnt < duty_q;
        end
    end

    assign duty     = duty_q;
    assign pwm      = pwm_q;
    assign busy     = state_q == RAMP;
    assign at_speed = state_q == HOLD;
    assign state    = state_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with default parameters
// (STEP=8, fast D=100, slow D=1000).
module tb_motor_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       run;
    logic       fast;
    logic       estop;
    logic [7:0] target;
    logic [7:0] duty;
    logic       pwm;
    logic       busy;
    logic       at_speed;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int n_hi;
    int exp_d;

    motor_ramp_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .run      (run),
        .fast     (fast),
        .estop    (estop),
        .target   (target),
        .duty     (duty),
        .pwm      (pwm),
        .busy     (busy),
        .at_speed (at_speed),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_pwm(output int n);
        n = 0;
        repeat (256) begin
            @(posedge clk);
            #1;
            n += int'(pwm);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        run    = 1'b0;
        fast   = 1'b1;
        estop  = 1'b0;
        target = 8'd0;
        step(3);
        chk("rst_duty", duty, 0);
        chk("rst_state", state, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_busy", busy, 0);
        chk("rst_at_speed", at_speed, 0);
        rst_n = 1'b1;
        step(2);

        // full fast ramp 0 -> 255
        run    = 1'b1;
        target = 8'd255;
        step(1);
        chk("up_busy", busy, 1);
        chk("up_state", state, 1);
        step(99);
        chk("up_pre_tick", duty, 0);
        step(1);
        chk("up_step1", duty, 8);
        for (int k = 2; k <= 31; k++) begin
            step(100);
            chk("up_step", duty, 8 * k);
        end
        step(100);
        chk("up_sat", duty, 255);
        chk("up_still_ramp", state, 1);
        step(1);
        chk("up_hold", state, 2);
        chk("up_at_speed", at_speed, 1);
        chk("up_not_busy", busy, 0);
        count_pwm(n_hi);
        chk("pwm_255", n_hi, 255);

        // slow ramp down to 0
        run  = 1'b0;
        fast = 1'b0;
        step(1);
        chk("dn_ramp", state, 1);
        for (int k = 1; k <= 32; k++) begin
            step(1000);
            exp_d = 255 - 8 * k;
            if (exp_d < 0) exp_d = 0;
            chk("dn_step", duty, exp_d);
        end
        chk("dn_still_ramp", state, 1);
        step(1);
        chk("dn_idle", state, 0);

        // retarget mid-ramp
        run    = 1'b1;
        fast   = 1'b1;
        target = 8'd200;
        step(1201);
        chk("rt_at96", duty, 96);
        target = 8'd40;
        for (int k = 1; k <= 7; k++) begin
            step(100);
            chk("rt_down", duty, 96 - 8 * k);
        end
        step(1);
        chk("rt_hold40", state, 2);
        target = 8'd45;
        step(1);
        chk("rt_ramp45", state, 1);
        step(100);
        chk("rt_duty45", duty, 45);
        step(1);
        chk("rt_hold45", state, 2);
        count_pwm(n_hi);
        chk("pwm_45", n_hi, 45);

        // fast switch past the fast threshold, then ena freeze
        target = 8'd100;
        fast   = 1'b0;
        step(501);
        chk("fs_no_tick", duty, 45);
        fast = 1'b1;
        step(1);
        chk("fs_tick", duty, 53);
        step(30);
        ena = 1'b0;
        step(50);
        chk("ena_frozen", duty, 53);
        chk("ena_state", state, 1);
        ena = 1'b1;
        step(69);
        chk("ena_pre_tick", duty, 53);
        step(1);
        chk("ena_tick", duty, 61);

        // estop with ena low
        ena   = 1'b0;
        estop = 1'b1;
        step(1);
        chk("es_duty", duty, 0);
        chk("es_state", state, 0);
        chk("es_pwm", pwm, 0);
        step(1);
        chk("es_held", duty, 0);
        estop = 1'b0;
        ena   = 1'b1;
        run   = 1'b0;
        step(1);
        chk("es_idle", state, 0);
        count_pwm(n_hi);
        chk("pwm_0", n_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
